// File: rtl/pipelined_cla_adder.sv
// ---------------------------------------------------------------------------
// pipelined_cla_adder
//   Pipelined carry-lookahead adder/subtractor with valid/ready handshake.
//   Each pipeline stage resolves SEG_WIDTH bits with 4-bit lookahead groups
//   (g=a&b, p=a|b, two-level carry expansion), rippling group carries inside
//   the segment and handing the segment carry to the next stage through a
//   register. Unresolved operand bits travel forward (skew) and resolved sum
//   bits travel forward (de-skew) so the full result emerges together.
//
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   in_valid/ready   input handshake; in_ready = ~out_valid | out_ready
//   in_a, in_b       operands (WIDTH)
//   in_ci            carry-in (add) / borrow-in (sub)
//   in_sub           1 = a - b - ci, 0 = a + b + ci
//   in_tag           sideband, returned with the result
//   out_valid/ready  output handshake
//   out_s            sum/difference modulo 2^WIDTH
//   out_co           carry-out of MSB (sub: 1 = no borrow)
//   out_ovf          signed overflow
//   out_tag          tag of this result
// ---------------------------------------------------------------------------
module pipelined_cla_adder #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned SEG_WIDTH = 8,
  parameter int unsigned TAG_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_ci,
  input  logic                 in_sub,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_s,
  output logic                 out_co,
  output logic                 out_ovf,
  output logic [TAG_WIDTH-1:0] out_tag
);

  localparam int unsigned STAGES = WIDTH / SEG_WIDTH;
  localparam int unsigned GROUPS = SEG_WIDTH / 4;

  // Stage registers. Operand/sum words are kept full width per stage; only the
  // skew (upper operand) and de-skew (lower sum) bits of each stage are live,
  // the rest are pruned by synthesis.
  logic                 r_v   [STAGES];
  logic [TAG_WIDTH-1:0] r_tag [STAGES];
  logic                 r_c   [STAGES];
  logic                 r_ovf [STAGES];
  logic [WIDTH-1:0]     r_a   [STAGES];
  logic [WIDTH-1:0]     r_b   [STAGES];
  logic [WIDTH-1:0]     r_s   [STAGES];

  logic                 w_en;
  logic                 w_c_eff;
  logic                 w_v_nxt   [STAGES];
  logic [TAG_WIDTH-1:0] w_tag_nxt [STAGES];
  logic                 w_c_nxt   [STAGES];
  logic                 w_ovf_nxt [STAGES];
  logic [WIDTH-1:0]     w_a_nxt   [STAGES];
  logic [WIDTH-1:0]     w_b_nxt   [STAGES];
  logic [WIDTH-1:0]     w_s_nxt   [STAGES];
  logic [SEG_WIDTH+1:0] w_seg     [STAGES];

  // Returns {carry_out, carry_into_segment_msb, sum[SEG_WIDTH-1:0]}.
  function automatic logic [SEG_WIDTH+1:0] f_seg_add(
    input logic [SEG_WIDTH-1:0] a,
    input logic [SEG_WIDTH-1:0] b,
    input logic                 cin
  );
    logic [SEG_WIDTH-1:0] g;
    logic [SEG_WIDTH-1:0] p;
    logic [SEG_WIDTH-1:0] c;
    logic                 cg;
    logic                 gg;
    logic                 pg;
    g  = a & b;
    p  = a | b;
    c  = '0;
    cg = cin;
    for (int unsigned j = 0; j < GROUPS; j++) begin
      c[4*j]   = cg;
      c[4*j+1] = g[4*j] | (p[4*j] & cg);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & cg);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1])
               | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & cg);
      // Group generate/propagate feed the carry into the next group.
      gg = g[4*j+3] | (p[4*j+3] & g[4*j+2])
         | (p[4*j+3] & p[4*j+2] & g[4*j+1])
         | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      pg = &p[4*j +: 4];
      cg = gg | (pg & cg);
    end
    return {cg, c[SEG_WIDTH-1], (a ^ b) ^ c};
  endfunction

  assign w_en     = ~r_v[STAGES-1] | out_ready;
  assign in_ready = w_en;
  assign w_c_eff  = in_ci ^ in_sub;

  always_comb begin
    // Stage 0 takes the conditioned operands straight from the inputs.
    w_v_nxt[0]   = in_valid;
    w_tag_nxt[0] = in_tag;
    w_a_nxt[0]   = in_a;
    w_b_nxt[0]   = in_b ^ {WIDTH{in_sub}};
    w_seg[0]     = f_seg_add(in_a[SEG_WIDTH-1:0],
                             in_b[SEG_WIDTH-1:0] ^ {SEG_WIDTH{in_sub}},
                             w_c_eff);
    w_s_nxt[0]   = '0;
    w_s_nxt[0][SEG_WIDTH-1:0] = w_seg[0][SEG_WIDTH-1:0];
    w_c_nxt[0]   = w_seg[0][SEG_WIDTH+1];
    w_ovf_nxt[0] = w_seg[0][SEG_WIDTH+1] ^ w_seg[0][SEG_WIDTH];

    for (int unsigned k = 1; k < STAGES; k++) begin
      w_v_nxt[k]   = r_v[k-1];
      w_tag_nxt[k] = r_tag[k-1];
      w_a_nxt[k]   = r_a[k-1];
      w_b_nxt[k]   = r_b[k-1];
      w_seg[k]     = f_seg_add(r_a[k-1][k*SEG_WIDTH +: SEG_WIDTH],
                               r_b[k-1][k*SEG_WIDTH +: SEG_WIDTH],
                               r_c[k-1]);
      w_s_nxt[k]   = r_s[k-1];
      w_s_nxt[k][k*SEG_WIDTH +: SEG_WIDTH] = w_seg[k][SEG_WIDTH-1:0];
      w_c_nxt[k]   = w_seg[k][SEG_WIDTH+1];
      // Only the last stage's value is used: it sees the true MSB carries.
      w_ovf_nxt[k] = w_seg[k][SEG_WIDTH+1] ^ w_seg[k][SEG_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        r_v[k]   <= 1'b0;
        r_tag[k] <= '0;
        r_c[k]   <= 1'b0;
        r_ovf[k] <= 1'b0;
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_s[k]   <= '0;
      end
    end else if (w_en) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        r_v[k]   <= w_v_nxt[k];
        r_tag[k] <= w_tag_nxt[k];
        r_c[k]   <= w_c_nxt[k];
        r_ovf[k] <= w_ovf_nxt[k];
        r_a[k]   <= w_a_nxt[k];
        r_b[k]   <= w_b_nxt[k];
        r_s[k]   <= w_s_nxt[k];
      end
    end
  end

  assign out_valid = r_v[STAGES-1];
  assign out_s     = r_s[STAGES-1];
  assign out_co    = r_c[STAGES-1];
  assign out_ovf   = r_ovf[STAGES-1];
  assign out_tag   = r_tag[STAGES-1];

endmodule
